// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - byte-stream boot loader that fills instruction memory and releases the core
module boot_loader #(
    parameter int         ADDR_W = 24,
    parameter int         DATA_W = 24,
    parameter int         DEPTH  = 4096,
    parameter logic [7:0] MAGIC  = 8'hA5
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_rx_valid,
    input  logic [7:0]        iw_rx_data,
    output logic              or_rx_ready,
    input  logic              iw_start,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    output logic              or_core_rst,
    output logic              or_done,
    output logic              or_error
);

    localparam int BPW = DATA_W / 8;

    typedef enum logic [2:0] {
        S_WAIT_MAGIC,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        len_cnt_q, len_cnt_d;
    logic [23:0]       len_q, len_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rx_ready_q, rx_ready_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic [23:0]       len_shift;
    logic [DATA_W-1:0] word_shift;
    logic              last_word;

    // Bytes arrive little-endian, so each new byte enters at the top and slides down.
    assign accept     = iw_rx_valid && rx_ready_q;
    assign len_shift  = {iw_rx_data, len_q[23:8]};
    assign word_shift = (word_q >> 8) | (DATA_W'(iw_rx_data) << (DATA_W - 8));
    assign last_word  = (32'(idx_q) == (32'(len_q) - 32'd1));

    assign or_rx_ready  = rx_ready_q;
    assign or_core_rst  = core_rst_q;
    assign or_done      = done_q;
    assign or_error     = error_q;
    assign ow_mem_we    = (state_q == S_WRITE);
    assign ow_mem_addr  = mem_addr_q;
    assign ow_mem_wdata = mem_wdata_q;

    // State register and registered status outputs
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q    <= S_WAIT_MAGIC;
            rx_ready_q <= 1'b1;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Next-state logic: frame parsing sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_MAGIC: if (accept && iw_rx_data == MAGIC) state_d = S_LEN;
            S_LEN: begin
                if (accept && len_cnt_q == 2'd2) begin
                    if (32'(len_shift) > 32'(DEPTH)) state_d = S_ERROR;
                    else if (len_shift == 24'd0)     state_d = S_CSUM;
                    else                             state_d = S_DATA;
                end
            end
            S_DATA:  if (accept && byte_cnt_q == 8'(BPW - 1)) state_d = S_WRITE;
            S_WRITE: state_d = last_word ? S_CSUM : S_DATA;
            S_CSUM:  if (accept) state_d = (iw_rx_data == csum_q) ? S_DONE : S_ERROR;
            S_DONE, S_ERROR: if (iw_start) state_d = S_WAIT_MAGIC;
            default: state_d = S_WAIT_MAGIC;
        endcase
    end

    // Output decode from the upcoming state so registered outputs track the state register
    always_comb begin
        rx_ready_d = (state_d == S_WAIT_MAGIC) || (state_d == S_LEN) ||
                     (state_d == S_DATA) || (state_d == S_CSUM);
        core_rst_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
    end

    // Datapath: length/word assembly, checksum, word index and write port values
    always_comb begin
        len_cnt_d   = len_cnt_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_WAIT_MAGIC: begin
                if (accept && iw_rx_data == MAGIC) begin
                    len_cnt_d  = 2'd0;
                    len_d      = 24'd0;
                    byte_cnt_d = 8'd0;
                    word_d     = '0;
                    idx_d      = '0;
                    csum_d     = 8'd0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d     = len_shift;
                    len_cnt_d = len_cnt_q + 2'd1;
                    csum_d    = csum_q ^ iw_rx_data;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d = word_shift;
                    csum_d = csum_q ^ iw_rx_data;
                    if (byte_cnt_q == 8'(BPW - 1)) begin
                        byte_cnt_d  = 8'd0;
                        mem_addr_d  = idx_q;
                        mem_wdata_d = word_shift;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            S_WRITE: idx_d = idx_q + 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            len_cnt_q   <= 2'd0;
            len_q       <= 24'd0;
            byte_cnt_q  <= 8'd0;
            word_q      <= '0;
            idx_q       <= '0;
            csum_q      <= 8'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            len_cnt_q   <= len_cnt_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule
